sram_nobl_arb_ctrl: RTL and testbench

//  Two-port round-robin arbiter + sequencer for one 512Kx36 NoBL pipelined SRAM (CY7C1370-class).

---
 rtl/sram_nobl_arb_ctrl.sv | 109 ++++++++++
 tb/tb_sram_nobl_arb_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_nobl_arb_ctrl.sv
// Two-port round-robin arbiter and NoBL (late-write) sequencer for a 512Kx36 pipelined SRAM.
// One accept per cycle; read data returns to the originating port a fixed 4 cycles after accept.
module sram_nobl_arb_ctrl #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 36,
   parameter int RD_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_wr,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [3:0]        p0_be,
   output logic              p0_ack,
   output logic              p0_rd_vld,
   output logic [DATA_W-1:0] p0_rd_data,
   input  logic              p1_req,
   input  logic              p1_wr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   input  logic [3:0]        p1_be,
   output logic              p1_ack,
   output logic              p1_rd_vld,
   output logic [DATA_W-1:0] p1_rd_data,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_we_b,
   output logic [3:0]        sram_bw_b,
   output logic              sram_cs_b,
   output logic              sram_adv_ld_b,
   output logic              sram_cen_b,
   output logic [DATA_W-1:0] sram_wr_data,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_rd_data
);

   localparam int STAGES = 4;

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [3:0]        be;
   } req_t;

   req_t              req0, req1, sel;
   logic              rd_block, elig0, elig1, gnt0, gnt1, acc, rr_ptr;
   logic [STAGES:1]   vld_pipe, wr_pipe, port_pipe;
   logic [DATA_W-1:0] wd_s1, wd_s2, rd_data;

   always_comb begin
      req0 = '{wr: p0_wr, addr: p0_addr, wdata: p0_wdata, be: p0_be};
      req1 = '{wr: p1_wr, addr: p1_addr, wdata: p1_wdata, be: p1_be};
      // A write right behind a read accept would drive dq while the SRAM still drives read data.
      rd_block = vld_pipe[1] & ~wr_pipe[1];
      elig0    = p0_req & ~(p0_wr & rd_block);
      elig1    = p1_req & ~(p1_wr & rd_block);
      gnt0     = ~reset & elig0 & (~elig1 | ~rr_ptr);
      gnt1     = ~reset & elig1 & (~elig0 | rr_ptr);
      acc      = gnt0 | gnt1;
      sel      = gnt1 ? req1 : req0;
   end

   assign p0_ack        = gnt0;
   assign p1_ack        = gnt1;
   assign p0_rd_vld     = vld_pipe[STAGES] & ~wr_pipe[STAGES] & ~port_pipe[STAGES];
   assign p1_rd_vld     = vld_pipe[STAGES] & ~wr_pipe[STAGES] &  port_pipe[STAGES];
   assign p0_rd_data    = rd_data;
   assign p1_rd_data    = rd_data;
   assign sram_adv_ld_b = 1'b0;
   assign sram_cen_b    = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= 1'b0;
         vld_pipe     <= '0;
         wr_pipe      <= '0;
         port_pipe    <= '0;
         sram_cs_b    <= 1'b1;
         sram_we_b    <= 1'b1;
         sram_bw_b    <= '1;
         sram_addr    <= '0;
         wd_s1        <= '0;
         wd_s2        <= '0;
         sram_wr_data <= '0;
         sram_dq_oe   <= 1'b0;
         rd_data      <= '0;
      end else begin
         if ((gnt0 && !rr_ptr) || (gnt1 && rr_ptr)) rr_ptr <= ~rr_ptr;
         vld_pipe  <= {vld_pipe[STAGES-1:1], acc};
         wr_pipe   <= {wr_pipe[STAGES-1:1], sel.wr};
         port_pipe <= {port_pipe[STAGES-1:1], gnt1};
         sram_cs_b <= ~acc;
         sram_we_b <= ~(acc & sel.wr);
         sram_bw_b <= (acc && sel.wr) ? ~sel.be : 4'hF;
         if (acc) begin
            sram_addr <= sel.addr;
            wd_s1     <= sel.wdata;
         end
         // Late write: data goes on dq two edges after the address edge.
         wd_s2        <= wd_s1;
         sram_wr_data <= wd_s2;
         sram_dq_oe   <= vld_pipe[2] & wr_pipe[2];
         if (vld_pipe[3] && !wr_pipe[3]) rd_data <= sram_rd_data;
         assert (RD_LAT == STAGES);
      end
   end

endmodule

// File: tb/tb_sram_nobl_arb_ctrl.sv
// Bench for sram_nobl_arb_ctrl: SRAM pin model, transaction-level scoreboard,
// arbitration vector table, directed corner cases and randomized two-port traffic.
module tb_sram_nobl_arb_ctrl;

   logic        clk = 0, reset = 1;
   logic        p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
   logic [18:0] p0_addr = 0, p1_addr = 0;
   logic [35:0] p0_wdata = 0, p1_wdata = 0;
   logic [3:0]  p0_be = 0, p1_be = 0;
   logic        p0_ack, p0_rd_vld, p1_ack, p1_rd_vld;
   logic [35:0] p0_rd_data, p1_rd_data;
   logic [18:0] sram_addr;
   logic        sram_we_b, sram_cs_b, sram_adv_ld_b, sram_cen_b, sram_dq_oe;
   logic [3:0]  sram_bw_b;
   logic [35:0] sram_wr_data, sram_rd_data;

   sram_nobl_arb_ctrl dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
      .p0_ack(p0_ack), .p0_rd_vld(p0_rd_vld), .p0_rd_data(p0_rd_data),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
      .p1_ack(p1_ack), .p1_rd_vld(p1_rd_vld), .p1_rd_data(p1_rd_data),
      .sram_addr(sram_addr), .sram_we_b(sram_we_b), .sram_bw_b(sram_bw_b), .sram_cs_b(sram_cs_b),
      .sram_adv_ld_b(sram_adv_ld_b), .sram_cen_b(sram_cen_b), .sram_wr_data(sram_wr_data),
      .sram_dq_oe(sram_dq_oe), .sram_rd_data(sram_rd_data));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   bit armed = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] nw, input logic [3:0] be);
      logic [35:0] r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[9*i +: 9] = nw[9*i +: 9];
      return r;
   endfunction

   // SRAM pin model: address at edge n, write data at edge n+2, read data driven after edge n+1
   typedef struct { bit v; bit wr; logic [18:0] a; logic [3:0] bw; } cmd_t;
   cmd_t c1 = '{0, 0, 0, 0}, c2 = '{0, 0, 0, 0};
   logic [35:0] sram_mem [int];

   always @(posedge clk) begin : sram_model
      bit exp_oe;
      logic [35:0] old, rnd;
      exp_oe = c2.v && c2.wr;
      if (armed) begin
         check("sram_dq_oe", sram_dq_oe, exp_oe);
         if (exp_oe) begin
            old = sram_mem.exists(int'(c2.a)) ? sram_mem[int'(c2.a)] : 36'h0;
            sram_mem[int'(c2.a)] = merge(old, sram_wr_data, ~c2.bw);
         end
      end
      rnd = {4'($urandom), 32'($urandom)};
      if (c1.v && !c1.wr)
         sram_rd_data <= sram_mem.exists(int'(c1.a)) ? sram_mem[int'(c1.a)] : 36'h0;
      else
         sram_rd_data <= rnd;
      if (reset) begin
         c1 <= '{0, 0, 0, 0};
         c2 <= '{0, 0, 0, 0};
      end else begin
         c2 <= c1;
         c1 <= '{(sram_cs_b === 1'b0), (sram_we_b === 1'b0), sram_addr, sram_bw_b};
      end
   end

   // Transaction-level reference: who should be granted, and what each read returns when
   typedef struct { int due; int port; logic [35:0] data; } rd_t;
   rd_t rq[$];
   logic [35:0] ref_mem [int];
   int  rrp = 0;
   bit  last_rd = 0, resync = 0;

   always @(negedge clk) begin : monitor
      bit e0, e1, g0, g1, wr;
      bit ev [2];
      logic [35:0] ed [2];
      int p;
      logic [18:0] a;
      if (armed) begin
         ev = '{0, 0};
         ed = '{36'h0, 36'h0};
         foreach (rq[i]) if (rq[i].due == cyc) begin ev[rq[i].port] = 1; ed[rq[i].port] = rq[i].data; end
         for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
         check("p0_rd_vld", p0_rd_vld, ev[0]);
         check("p1_rd_vld", p1_rd_vld, ev[1]);
         if (ev[0]) check("p0_rd_data", p0_rd_data, ed[0]);
         if (ev[1]) check("p1_rd_data", p1_rd_data, ed[1]);
         if (reset) begin
            check("p0_ack_in_reset", p0_ack, 0);
            check("p1_ack_in_reset", p1_ack, 0);
            rrp = 0; last_rd = 0; resync = 1;
            rq.delete();
         end else begin
            if (resync) begin ref_mem = sram_mem; resync = 0; end
            e0 = p0_req && !(p0_wr && last_rd);
            e1 = p1_req && !(p1_wr && last_rd);
            if (e0 && e1) begin g0 = (rrp == 0); g1 = (rrp == 1); end
            else begin g0 = e0; g1 = e1; end
            check("p0_ack", p0_ack, g0);
            check("p1_ack", p1_ack, g1);
            if (g0 || g1) begin
               p  = g1 ? 1 : 0;
               wr = g1 ? p1_wr : p0_wr;
               a  = g1 ? p1_addr : p0_addr;
               if (wr)
                  ref_mem[int'(a)] = merge(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 36'h0,
                                           g1 ? p1_wdata : p0_wdata, g1 ? p1_be : p0_be);
               else
                  rq.push_back('{cyc + 4, p, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 36'h0});
               if (p == rrp) rrp = 1 - rrp;
               last_rd = !wr;
            end else last_rd = 0;
         end
      end
   end

   // Hold a request until acked (bounded), return the ack cycle or -1
   task automatic do_req(input int p, input bit wr, input logic [18:0] a, input logic [35:0] d,
                         input logic [3:0] be, output int t_ack);
      bit got = 0;
      t_ack = -1;
      if (p == 0) begin p0_req = 1; p0_wr = wr; p0_addr = a; p0_wdata = d; p0_be = be; end
      else        begin p1_req = 1; p1_wr = wr; p1_addr = a; p1_wdata = d; p1_be = be; end
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if ((p == 0 ? p0_ack : p1_ack) === 1'b1) begin got = 1; t_ack = cyc; end
         @(posedge clk); #1;
      end
      if (!got) check("ack_timeout", 0, 1);
      if (p == 0) p0_req = 0; else p1_req = 0;
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   typedef struct { bit r0, w0, r1, w1, a0, a1; } vec_t;
   vec_t tbl [11];

   initial begin : watchdog
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin : main
      int t, ta, tb;
      int t0 [4], t1 [4];
      logic [35:0] d;
      // {r0,w0,r1,w1, ack0,ack1}; sequence starts from a fresh reset (pointer at port 0)
      tbl[0]  = '{1, 0, 1, 0, 1, 0};
      tbl[1]  = '{0, 0, 1, 0, 0, 1};
      tbl[2]  = '{1, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 1, 0, 0, 1, 0};
      tbl[4]  = '{1, 0, 1, 1, 0, 1};
      tbl[5]  = '{1, 0, 0, 0, 1, 0};
      tbl[6]  = '{1, 1, 1, 0, 0, 1};
      tbl[7]  = '{1, 1, 1, 1, 0, 0};
      tbl[8]  = '{1, 1, 1, 1, 1, 0};
      tbl[9]  = '{0, 0, 1, 1, 0, 1};
      tbl[10] = '{0, 0, 0, 0, 0, 0};

      // Reset held with a pending request
      idle(2);
      armed = 1;
      p0_req = 1; p0_wr = 0; p0_addr = 19'h0;
      repeat (3) begin
         @(negedge clk);
         check("rst_ack", p0_ack, 0);
         check("rst_cs_b", sram_cs_b, 1);
         check("rst_dq_oe", sram_dq_oe, 0);
         check("rst_we_b", sram_we_b, 1);
         check("rst_bw_b", sram_bw_b, 4'hF);
         @(posedge clk); #1;
      end
      reset = 0;
      @(negedge clk);
      check("first_ack", p0_ack, 1);
      @(posedge clk); #1;
      p0_req = 0;
      idle(6);

      // Arbitration vector table
      reset = 1; idle(2); reset = 0;
      foreach (tbl[i]) begin
         p0_req = tbl[i].r0; p0_wr = tbl[i].w0; p0_addr = 19'h200; p0_wdata = 36'hA5A5A5A5A; p0_be = 4'hF;
         p1_req = tbl[i].r1; p1_wr = tbl[i].w1; p1_addr = 19'h201; p1_wdata = 36'h5A5A5A5A5; p1_be = 4'hF;
         @(negedge clk);
         check($sformatf("tbl%0d_ack0", i), p0_ack, tbl[i].a0);
         check($sformatf("tbl%0d_ack1", i), p1_ack, tbl[i].a1);
         @(posedge clk); #1;
      end
      p0_req = 0; p1_req = 0;
      idle(6);

      // Write then read back, exact latency, no stray rd_vld on p1
      do_req(0, 1, 19'h10, 36'h123456789, 4'hF, t);
      do_req(0, 0, 19'h10, 36'h0, 4'h0, t);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("wr_rd_p1_vld", p1_rd_vld, 0);
         if (k == 3) check("wr_rd_early_vld", p0_rd_vld, 0);
         if (k == 4) begin
            check("wr_rd_vld", p0_rd_vld, 1);
            check("wr_rd_data", p0_rd_data, 36'h123456789);
         end
      end

      // Byte lanes at the top address
      do_req(0, 1, 19'h7FFFF, {36{1'b1}}, 4'hF, t);
      do_req(0, 1, 19'h7FFFF, 36'h0, 4'b0101, t);
      do_req(0, 0, 19'h7FFFF, 36'h0, 4'h0, t);
      wait_cyc(t + 4);
      check("be_vld", p0_rd_vld, 1);
      check("be_data", p0_rd_data, 36'hFF803FE00);
      idle(2);

      // Fairness: both ports stream reads
      for (int i = 0; i < 8; i++) do_req(i % 2, 1, 19'h40 + 19'(i), 36'hC00000000 + 36'(i * 4097), 4'hF, t);
      fork
         for (int i = 0; i < 4; i++) do_req(0, 0, 19'h40 + 19'(2 * i), 36'h0, 4'h0, t0[i]);
         for (int i = 0; i < 4; i++) do_req(1, 0, 19'h41 + 19'(2 * i), 36'h0, 4'h0, t1[i]);
      join
      check("fair_first", (t0[0] > t1[0]) ? t0[0] - t1[0] : t1[0] - t0[0], 1);
      for (int i = 1; i < 4; i++) begin
         check("fair_gap_p0", t0[i] - t0[i-1], 2);
         check("fair_gap_p1", t1[i] - t1[i-1], 2);
      end
      idle(6);

      // Read->write turnaround bubble, write->read no bubble
      fork
         do_req(0, 0, 19'h40, 36'h0, 4'h0, ta);
         begin idle(1); do_req(1, 1, 19'h50, 36'h987654321, 4'hF, tb); end
      join
      check("turn_gap", tb - ta, 2);
      wait_cyc(ta + 4);
      check("turn_dq_oe", sram_dq_oe, 0);
      idle(6);
      fork
         do_req(0, 1, 19'h51, 36'h0DEADBEEF, 4'hF, ta);
         begin idle(1); do_req(1, 0, 19'h51, 36'h0, 4'h0, tb); end
      join
      check("wr_rd_gap", tb - ta, 1);
      wait_cyc(tb + 4);
      check("wr_rd_fwd_vld", p1_rd_vld, 1);
      check("wr_rd_fwd_data", p1_rd_data, 36'h0DEADBEEF);
      idle(4);

      // Reset in T+2 of a read, then of a write
      do_req(0, 0, 19'h10, 36'h0, 4'h0, t);
      reset = 1; idle(1); reset = 0;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         check("midrst_rd_vld", p0_rd_vld | p1_rd_vld, 0);
      end
      idle(3);
      do_req(0, 1, 19'h20, 36'h111111111, 4'hF, t);
      reset = 1; idle(1); reset = 0;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         check("midrst_dq_oe", sram_dq_oe, 0);
      end
      idle(3);

      // Randomized two-port traffic against the reference model
      fork
         for (int i = 0; i < 60; i++) begin
            int dl;
            logic [35:0] rd0;
            dl = $urandom_range(2, 0);
            idle(dl);
            rd0 = {4'($urandom), 32'($urandom)};
            do_req(0, 1'($urandom), 19'(32'h300 + $urandom_range(15, 0)), rd0, 4'($urandom), t);
         end
         for (int i = 0; i < 60; i++) begin
            int dl;
            logic [35:0] rd1;
            int t_r;
            dl = $urandom_range(2, 0);
            idle(dl);
            rd1 = {4'($urandom), 32'($urandom)};
            do_req(1, 1'($urandom), 19'(32'h300 + $urandom_range(15, 0)), rd1, 4'($urandom), t_r);
         end
      join
      idle(8);
      d = 36'h0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + int'(d));
      $finish;
   end

endmodule
